// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_REQ  = 2'd0;
   localparam state_t S_HOLD = 2'd1;
   localparam state_t S_DROP = 2'd2;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/if_fetch_stage_pc_next.sv
// Next-PC select for the fetch stage: chooses between hold, sequential,
// redirect target and the parked target of a dropped fetch.
module if_pc_next
   import if_fetch_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  state_t              state,
   input  logic [DATA_W-1:0]   pc,
   input  logic [DATA_W-1:0]   pend,
   input  logic [DATA_W-1:0]   target,
   input  logic                redirect_en,
   input  logic                stall,
   input  logic                imem_ack,
   output logic [DATA_W-1:0]   pc_next
);

   logic [DATA_W-1:0] target_al;
   logic [DATA_W-1:0] pc_seq;

   assign target_al = target & ~DATA_W'(3);
   assign pc_seq    = pc + DATA_W'(PC_INC);

   // Redirect beats stall; the address never moves while a request is unanswered.
   always_comb begin
      pc_next = pc;
      case (state)
         S_REQ: begin
            if (redirect_en) begin
               if (imem_ack) pc_next = target_al;
            end else if (imem_ack && !stall) begin
               pc_next = pc_seq;
            end
         end
         S_HOLD: begin
            if (redirect_en)  pc_next = target_al;
            else if (!stall)  pc_next = pc_seq;
         end
         S_DROP: begin
            if (imem_ack) pc_next = redirect_en ? target_al : pend;
         end
         default: pc_next = pc;
      endcase
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack instruction-memory
// handshake and presents instruction / PC+4 / valid to the IF/ID register.
//
// state  | meaning
// S_REQ  | request outstanding at pc; ack with no redirect delivers an instruction
// S_HOLD | instruction parked in instr_buf while ID stalls; no memory request
// S_DROP | wrong-path request still in flight; its data is discarded, then pc<=pend
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_en,
   input  logic [DATA_W-1:0] redirect_target,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] IF_Instruction,
   output logic [DATA_W-1:0] IF_PC_p4,
   output logic              IF_valid
);

   state_t            state;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] instr_buf;
   logic [DATA_W-1:0] pend_pc;
   logic [DATA_W-1:0] pc_next;
   logic [DATA_W-1:0] target_al;

   assign target_al = redirect_target & ~DATA_W'(3);

   if_pc_next #(.DATA_W(DATA_W)) u_pc_next (
      .state       (state),
      .pc          (pc),
      .pend        (pend_pc),
      .target      (redirect_target),
      .redirect_en (redirect_en),
      .stall       (stall),
      .imem_ack    (imem_ack),
      .pc_next     (pc_next)
   );

   // PC, hold buffer, parked redirect target and FSM state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         instr_buf <= '0;
         pend_pc   <= '0;
         state     <= S_REQ;
      end else begin
         pc <= pc_next;
         case (state)
            S_REQ: begin
               if (redirect_en) begin
                  if (!imem_ack) begin
                     pend_pc <= target_al;
                     state   <= S_DROP;
                  end
               end else if (imem_ack && stall) begin
                  instr_buf <= imem_rdata;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (redirect_en || !stall) state <= S_REQ;
            end
            S_DROP: begin
               if (imem_ack)         state   <= S_REQ;
               else if (redirect_en) pend_pc <= target_al;
            end
            default: state <= S_REQ;
         endcase
      end
   end

   // Memory request and IF/ID presentation; reset gates the request immediately.
   always_comb begin
      imem_req       = 1'b0;
      IF_valid       = 1'b0;
      IF_Instruction = DATA_W'(NOP_INSTR);
      if (!reset) begin
         case (state)
            S_REQ: begin
               imem_req = 1'b1;
               if (!redirect_en && imem_ack) begin
                  IF_valid       = 1'b1;
                  IF_Instruction = imem_rdata;
               end
            end
            S_HOLD: begin
               if (!redirect_en) begin
                  IF_valid       = 1'b1;
                  IF_Instruction = instr_buf;
               end
            end
            S_DROP: imem_req = 1'b1;
            default: imem_req = 1'b0;
         endcase
      end
   end

   assign imem_addr = pc;
   assign IF_PC_p4  = pc + DATA_W'(PC_INC);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for the instruction-fetch stage.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IF_Instruction;
   logic [31:0] IF_PC_p4;
   logic        IF_valid;

   int n_checks = 0;
   int n_fail   = 0;

   if_fetch_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_en     (redirect_en),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .IF_Instruction  (IF_Instruction),
      .IF_PC_p4        (IF_PC_p4),
      .IF_valid        (IF_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs and let combinational outputs settle.
   task automatic drive(input logic red, input logic [31:0] tgt, input logic stl,
                        input logic ack, input logic [31:0] rd);
      redirect_en     = red;
      redirect_target = tgt;
      stall           = stl;
      imem_ack        = ack;
      imem_rdata      = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the full presented bundle for the current cycle.
   task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] ins);
      check({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
      check({tag, ".addr"},  imem_addr, addr);
      check({tag, ".valid"}, {31'd0, IF_valid}, {31'd0, vld});
      check({tag, ".instr"}, IF_Instruction, ins);
      check({tag, ".pc_p4"}, IF_PC_p4, addr + 32'd4);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      expect_out("rst", 1'b0, 32'h0040_0000, 1'b0, 32'h0);
      #1 reset = 1'b0;

      // Back-to-back single-cycle fetches.
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0000);
      expect_out("seq0", 1'b1, 32'h0040_0000, 1'b1, 32'h1111_0000);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0001);
      expect_out("seq1", 1'b1, 32'h0040_0004, 1'b1, 32'h1111_0001);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0002);
      expect_out("seq2", 1'b1, 32'h0040_0008, 1'b1, 32'h1111_0002);
      tick();

      // Two wait cycles before ack.
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      expect_out("wait0", 1'b1, 32'h0040_000C, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      expect_out("wait1", 1'b1, 32'h0040_000C, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0000);
      expect_out("wait_ack", 1'b1, 32'h0040_000C, 1'b1, 32'h2222_0000);
      tick();

      // Ack under stall parks the instruction in the hold buffer.
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8C88_0004);
      expect_out("stall_ack", 1'b1, 32'h0040_0010, 1'b1, 32'h8C88_0004);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h5555_5555);
      expect_out("hold0", 1'b0, 32'h0040_0010, 1'b1, 32'h8C88_0004);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h5555_5555);
      expect_out("hold1", 1'b0, 32'h0040_0010, 1'b1, 32'h8C88_0004);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("after_hold", 1'b1, 32'h0040_0014, 1'b0, 32'h0);

      // Redirect while a request is unanswered: drop the late data.
      drive(1'b1, 32'h0040_0103, 1'b0, 1'b0, 32'h0);
      expect_out("drop_red", 1'b1, 32'h0040_0014, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("drop_wait", 1'b1, 32'h0040_0014, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
      expect_out("drop_ack", 1'b1, 32'h0040_0014, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h3333_0000);
      expect_out("drop_new", 1'b1, 32'h0040_0100, 1'b1, 32'h3333_0000);
      tick();

      // Redirect together with stall while holding.
      drive(1'b1, 32'h0040_0040, 1'b1, 1'b0, 32'h0);
      expect_out("hold_red", 1'b0, 32'h0040_0100, 1'b0, 32'h0);
      tick();
      drive(1'b1, 32'h0040_0200, 1'b0, 1'b0, 32'h0);
      expect_out("hold_red_new", 1'b1, 32'h0040_0040, 1'b0, 32'h0);
      tick();

      // Second redirect while dropping: the younger target wins.
      drive(1'b1, 32'h0040_0300, 1'b0, 1'b0, 32'h0);
      expect_out("drop_twice", 1'b1, 32'h0040_0040, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD_0BAD);
      expect_out("drop_twice_ack", 1'b1, 32'h0040_0040, 1'b0, 32'h0);
      tick();

      // Redirect on an acked request, with PC+4 wraparound at the top.
      drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h4444_0000);
      expect_out("red_ack", 1'b1, 32'h0040_0300, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
      check("wrap.pc_p4", IF_PC_p4, 32'h0000_0000);

      // Async reset in the middle of a drop.
      drive(1'b1, 32'h0040_0500, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("pre_rst.req", {31'd0, imem_req}, 32'd1);
      #1 reset = 1'b1;
      #1;
      expect_out("mid_rst", 1'b0, 32'h0040_0000, 1'b0, 32'h0);
      check("mid_rst.pend", dut.pend_pc, 32'h0);
      #1 reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_0000);
      expect_out("post_rst", 1'b1, 32'h0040_0000, 1'b1, 32'h6666_0000);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_0001);
      expect_out("post_rst1", 1'b1, 32'h0040_0004, 1'b1, 32'h6666_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC and drives a request/acknowledge instruction-memory port that may take one or more cycles per access. Presents instruction, PC+4 and a valid flag to IF/ID. Honours hazard stalls from ID and redirects (branch/jump) from later stages, including redirects that arrive while a memory access is still in flight.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset; low 2 bits must be 0.
DATA_W, 32, instruction and address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  ID hazard hold; IF/ID will not capture this cycle.
redirect_en  in  1  branch/jump taken; current fetch is wrong-path.
redirect_target  in  32  new PC; bits [1:0] ignored (forced 0).
imem_req  out  1  instruction-memory request, held until imem_ack.
imem_addr  out  32  fetch address, stable while imem_req=1.
imem_ack  in  1  memory response; imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction.
IF_Instruction  out  32  instruction to IF/ID; 32'h0 (NOP) when IF_valid=0.
IF_PC_p4  out  32  PC of presented instruction + 4.
IF_valid  out  1  IF_Instruction is a real, right-path instruction.

Behaviour:
- Registers: pc (32), buf (32), pend (32), state. Reset (async): pc=RESET_PC, buf=0, pend=0, state=S_REQ.
- Output reset values: imem_req=0 while reset is high; IF_valid=0; IF_Instruction=0; IF_PC_p4=RESET_PC+4.
- imem_addr=pc in all states. IF_PC_p4=pc+4, mod 2^32 (wraps 32'hFFFF_FFFC -> 0).
- S_REQ: imem_req=1.
  - redirect_en=1: IF_valid=0. If imem_ack=1: pc<=target, stay S_REQ. If imem_ack=0: pend<=target, go to S_DROP. The address must not change mid-request.
  - No redirect, imem_ack=1: IF_valid=1, IF_Instruction=imem_rdata (combinational pass-through). If stall=0: pc<=pc+4, stay S_REQ. If stall=1: buf<=imem_rdata, go to S_HOLD.
  - No redirect, imem_ack=0: IF_valid=0, hold.
- S_HOLD: imem_req=0. IF_valid=1, IF_Instruction=buf.
  - redirect_en=1: IF_valid=0, pc<=target, go to S_REQ.
  - Else if stall=0: pc<=pc+4, go to S_REQ.
  - Else hold.
- S_DROP: imem_req=1 at the old pc. IF_valid=0.
  - imem_ack=1: data is discarded; pc<=pend, go to S_REQ.
  - A further redirect_en in S_DROP overwrites pend (youngest target wins). On the ack cycle, a redirect goes straight to pc.
- Priority: reset > redirect_en > stall. redirect_en together with stall is handled as a redirect.
- Throughput: one instruction per cycle when imem_ack is asserted in the request cycle and there are no stalls. An N-cycle memory gives one instruction per N cycles.
- IF/ID hookup: wen = ~stall; Flush = ~IF_valid.

Decomposition:
- Shared package holds: state enum (S_REQ, S_HOLD, S_DROP; 2-bit), NOP_INSTR=32'h0, RESET_PC default, PC_INC=4.
- One sub-module, if_pc_next: combinational next-pc select over {pc, pc+4, target&~3, pend} with the priority above. The FSM and registers stay in the top module.

Test Plan:
- Reset release, imem_ack tied 1, stall=0 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; IF_valid=1 each cycle; IF_PC_p4 = addr+4.
- Ack on the 3rd cycle of the request (2 wait cycles) -> imem_addr held constant for 3 cycles; IF_valid=1 only on the ack cycle; pc advances once.
- Ack with stall=1 for 2 cycles, rdata=0x8C880004 -> S_HOLD, imem_req=0, IF_Instruction=0x8C880004 held for 2 cycles; fetch of pc+4 starts the cycle after stall drops.
- Redirect to 0x00400103 while a request is pending with no ack, ack 2 cycles later -> data discarded, IF_valid=0 throughout, next imem_addr=0x00400100.
- redirect_en and stall both high in S_HOLD, target 0x00400040 -> IF_valid=0 that cycle; next request at 0x00400040.
- Async reset asserted mid-wait in S_DROP -> imem_req drops immediately; after release pc=0x00400000 and pend is cleared; the first request is at RESET_PC.
